// File: rtl/operand_capture.sv
// operand_capture: synchronises/debounces START, samples switches, latches two operands and holds them until acknowledged.
// Define OPERAND_CAPTURE_SIGN_MAG_EN to read the switches as sign-magnitude instead of two's complement.
module operand_capture #(
    parameter int DW              = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_switches,
    input  logic          i_start,
    input  logic          i_ack,
    output logic [DW-1:0] o_multiplicand,
    output logic [DW-1:0] o_multiplier,
    output logic          o_valid,
    output logic [1:0]    o_stage
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {S_OPA = 2'd0, S_OPB = 2'd1, S_VALID = 2'd2} state_t;

    state_t        r_state;
    logic          r_start_m, r_start_s;
    logic [DW-1:0] r_sw_m, r_sw_s;
    logic          r_db_level, r_db_last;
    logic [CW-1:0] r_db_cnt;
    logic [DW-1:0] r_mcand, r_mplier;
    logic          r_valid;
    logic          w_press;
    logic [DW-1:0] w_conv;

`ifdef OPERAND_CAPTURE_SIGN_MAG_EN
    logic [DW-1:0] w_mag;
    assign w_mag  = {1'b0, r_sw_s[DW-2:0]};
    assign w_conv = r_sw_s[DW-1] ? -w_mag : w_mag;
`else
    assign w_conv = r_sw_s;
`endif

    assign w_press        = r_db_level & ~r_db_last;
    assign o_multiplicand = r_mcand;
    assign o_multiplier   = r_mplier;
    assign o_valid        = r_valid;
    assign o_stage        = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_m <= 1'b0;
            r_start_s <= 1'b0;
            r_sw_m    <= '0;
            r_sw_s    <= '0;
        end else begin
            r_start_m <= i_start;
            r_start_s <= r_start_m;
            r_sw_m    <= i_switches;
            r_sw_s    <= r_sw_m;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db_level <= 1'b0;
            r_db_last  <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_db_last <= r_db_level;
            if (r_start_s == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db_cnt   <= '0;
                r_db_level <= r_start_s;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_OPA;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_OPA: if (w_press) begin
                    r_mcand <= w_conv;
                    r_state <= S_OPB;
                end
                S_OPB: if (w_press) begin
                    r_mplier <= w_conv;
                    r_valid  <= 1'b1;
                    r_state  <= S_VALID;
                end
                S_VALID: if (i_ack) begin
                    r_valid <= 1'b0;
                    r_state <= S_OPA;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_OPA;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_operand_capture.sv
// tb_operand_capture: directed checks of debounce timing, capture sequencing, ack handling and async reset.
module tb_operand_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] mcand, mplier;
    logic       valid;
    logic [1:0] stage;
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_83, exp_80;

    operand_capture #(.DW(8), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_switches(sw), .i_start(start), .i_ack(ack),
        .o_multiplicand(mcand), .o_multiplier(mplier), .o_valid(valid), .o_stage(stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_release(input logic [7:0] v);
        sw = v;
        start = 1'b1;
        tick(10);
        start = 1'b0;
        tick(8);
    endtask

    initial begin
`ifdef OPERAND_CAPTURE_SIGN_MAG_EN
        exp_83 = 8'hFD;
        exp_80 = 8'h00;
`else
        exp_83 = 8'h83;
        exp_80 = 8'h80;
`endif
        #1;
        chk("reset_mcand", mcand, 8'h00);
        chk("reset_mplier", mplier, 8'h00);
        chk("reset_valid", valid, 1'b0);
        chk("reset_stage", stage, 2'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        press_release(8'h05);
        chk("opa_stage", stage, 2'd1);
        chk("opa_mcand", mcand, 8'h05);
        chk("opa_valid", valid, 1'b0);
        press_release(8'hFD);
        chk("opb_mplier", mplier, 8'hFD);
        chk("opb_valid", valid, 1'b1);
        chk("opb_stage", stage, 2'd2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_valid", valid, 1'b0);
        chk("ack_stage", stage, 2'd0);
        chk("ack_keep_mcand", mcand, 8'h05);

        sw = 8'h12;
        start = 1'b1; tick(1);
        start = 1'b0; tick(1);
        start = 1'b1; tick(1);
        start = 1'b0; tick(1);
        start = 1'b1;
        tick(6);
        chk("bounce_before_press", stage, 2'd0);
        tick(1);
        chk("bounce_at_press", stage, 2'd1);
        chk("bounce_mcand", mcand, 8'h12);
        tick(3);
        start = 1'b0;
        tick(8);
        chk("bounce_one_capture", stage, 2'd1);

        sw = 8'hA5;
        start = 1'b1;
        tick(100);
        chk("hold_stage", stage, 2'd2);
        chk("hold_mplier", mplier, 8'hA5);
        chk("hold_mcand", mcand, 8'h12);
        start = 1'b0;
        tick(8);
        press_release(8'h7F);
        chk("ignore_mcand", mcand, 8'h12);
        chk("ignore_mplier", mplier, 8'hA5);
        chk("ignore_valid", valid, 1'b1);
        chk("ignore_stage", stage, 2'd2);

        sw = 8'h33;
        start = 1'b1;
        tick(6);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("simul_stage", stage, 2'd0);
        chk("simul_mcand", mcand, 8'h12);
        chk("simul_valid", valid, 1'b0);
        tick(3);
        start = 1'b0;
        tick(8);
        chk("simul_not_queued", stage, 2'd0);

        press_release(8'h83);
        chk("conv_83", mcand, exp_83);
        press_release(8'h80);
        chk("conv_80", mplier, exp_80);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        press_release(8'h7F);
        chk("conv_7f", mcand, 8'h7F);
        press_release(8'h05);
        chk("pre_reset_valid", valid, 1'b1);

        #2 rst_n = 1'b0;
        #1;
        chk("async_mcand", mcand, 8'h00);
        chk("async_mplier", mplier, 8'h00);
        chk("async_valid", valid, 1'b0);
        chk("async_stage", stage, 2'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("post_reset_no_press", stage, 2'd0);
        press_release(8'h44);
        chk("post_reset_fresh_press", mcand, 8'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
